// File: rtl/branch_pc_unit_pkg.sv
// Shared branch-type codes, 2-bit counter states and counter helpers for the branch/PC unit.
// The optional predictor is enabled with BRANCH_PREDICT_EN.
package branch_pc_unit_pkg;

  typedef enum logic [3:0] {
    BRANCH_NONE = 4'd0,
    BRANCH_EQ   = 4'd1,
    BRANCH_NE   = 4'd2,
    BRANCH_LT   = 4'd3,
    BRANCH_GE   = 4'd4,
    BRANCH_LTU  = 4'd5,
    BRANCH_GEU  = 4'd6,
    BRANCH_JAL  = 4'd7,
    BRANCH_JALR = 4'd8
  } branch_e;

  typedef enum logic [1:0] {
    CTR_SNT = 2'd0,
    CTR_WNT = 2'd1,
    CTR_WT  = 2'd2,
    CTR_ST  = 2'd3
  } ctr_e;

  function automatic logic is_branch(input logic [3:0] t);
    return (t >= BRANCH_EQ) && (t <= BRANCH_JALR);
  endfunction

  // Saturating up/down step of a 2-bit direction counter.
  function automatic ctr_e ctr_update(input ctr_e c, input logic t);
    ctr_e n;
    n = c;
    case (c)
      CTR_SNT: n = t ? CTR_WNT : CTR_SNT;
      CTR_WNT: n = t ? CTR_WT  : CTR_SNT;
      CTR_WT:  n = t ? CTR_ST  : CTR_WNT;
      CTR_ST:  n = t ? CTR_ST  : CTR_WT;
      default: n = CTR_WNT;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/branch_predictor.sv
// Direct-mapped taken-branch table: {valid, target, 2-bit counter} per entry.
// Only instantiated by branch_pc_unit when BRANCH_PREDICT_EN is defined.
module branch_predictor
  import branch_pc_unit_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [XLEN-1:0] i_lookup_pc,
  output logic            o_pred_taken,
  output logic [XLEN-1:0] o_pred_target,
  input  logic            i_upd_en,
  input  logic [XLEN-1:0] i_upd_pc,
  input  logic [XLEN-1:0] i_upd_target,
  input  logic            i_upd_taken,
  input  logic            i_upd_jump
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic            r_valid  [ENTRIES];
  logic [XLEN-1:0] r_target [ENTRIES];
  ctr_e            r_ctr    [ENTRIES];

  logic [IDX_W-1:0] w_lk_idx;
  logic [IDX_W-1:0] w_up_idx;
  logic             w_unused_bits;

  assign w_lk_idx      = i_lookup_pc[IDX_W+1:2];
  assign w_up_idx      = i_upd_pc[IDX_W+1:2];
  assign w_unused_bits = ^{i_lookup_pc[XLEN-1:IDX_W+2], i_lookup_pc[1:0],
                           i_upd_pc[XLEN-1:IDX_W+2], i_upd_pc[1:0]};

  // Lookup reads the registered entry, so a same-cycle update is not visible yet.
  assign o_pred_taken  = r_valid[w_lk_idx] && (r_ctr[w_lk_idx] >= CTR_WT);
  assign o_pred_target = r_target[w_lk_idx];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= CTR_WNT;
      end
    end else if (i_upd_en) begin
      r_valid[w_up_idx]  <= 1'b1;
      r_target[w_up_idx] <= i_upd_target;
      r_ctr[w_up_idx]    <= i_upd_jump ? CTR_ST : ctr_update(r_ctr[w_up_idx], i_upd_taken);
    end
  end

endmodule

// File: rtl/branch_pc_unit.sv
// Fetch PC register plus branch/jump resolution and mispredict redirect.
// Define BRANCH_PREDICT_EN to add the direct-mapped taken predictor.
module branch_pc_unit
  import branch_pc_unit_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int              BTB_ENTRIES = 16
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            stall,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] immediate,
  input  logic [3:0]      branch_type,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic [XLEN-1:0] pc,
  output logic            pred_taken,
  output logic            redirect,
  output logic            taken,
  output logic            misaligned
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic [XLEN-1:0] r_pc;
  logic            w_dir;
  logic            w_taken;
  logic            w_redirect;
  logic [XLEN-1:0] w_jalr_sum;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_fall;
  logic            w_pred_taken;
  logic [XLEN-1:0] w_pred_target;

  always_comb begin
    w_dir = 1'b0;
    case (branch_type)
      BRANCH_EQ:   w_dir = (rs1_data == rs2_data);
      BRANCH_NE:   w_dir = (rs1_data != rs2_data);
      BRANCH_LT:   w_dir = ($signed(rs1_data) <  $signed(rs2_data));
      BRANCH_GE:   w_dir = ($signed(rs1_data) >= $signed(rs2_data));
      BRANCH_LTU:  w_dir = (rs1_data <  rs2_data);
      BRANCH_GEU:  w_dir = (rs1_data >= rs2_data);
      BRANCH_JAL:  w_dir = 1'b1;
      BRANCH_JALR: w_dir = 1'b1;
      default:     w_dir = 1'b0;
    endcase
  end

  assign w_jalr_sum = rs1_data + immediate;
  assign w_target   = (branch_type == BRANCH_JALR) ? {w_jalr_sum[XLEN-1:1], 1'b0}
                                                   : ex_pc + immediate;
  assign w_fall     = ex_pc + PC_STEP;
  assign w_taken    = ex_valid && w_dir;
  assign w_redirect = ex_valid && ((w_taken != ex_pred_taken) ||
                                   (w_taken && (w_target != ex_pred_target)));

`ifdef BRANCH_PREDICT_EN
  branch_predictor #(
    .XLEN    (XLEN),
    .ENTRIES (BTB_ENTRIES)
  ) u_predictor (
    .clock         (clock),
    .reset_n       (reset_n),
    .i_lookup_pc   (r_pc),
    .o_pred_taken  (w_pred_taken),
    .o_pred_target (w_pred_target),
    .i_upd_en      (ex_valid && is_branch(branch_type)),
    .i_upd_pc      (ex_pc),
    .i_upd_target  (w_target),
    .i_upd_taken   (w_taken),
    .i_upd_jump    ((branch_type == BRANCH_JAL) || (branch_type == BRANCH_JALR))
  );
`else
  logic w_unused_cfg;
  assign w_unused_cfg  = (BTB_ENTRIES > 1);
  assign w_pred_taken  = 1'b0;
  assign w_pred_target = '0;
`endif

  // Status outputs read as zero while reset is asserted.
  assign pc         = r_pc;
  assign pred_taken = reset_n && w_pred_taken;
  assign redirect   = reset_n && w_redirect;
  assign taken      = reset_n && w_taken;
  assign misaligned = reset_n && w_taken && (w_target[1:0] != 2'b00);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_pc <= RESET_PC;
    end else if (w_redirect) begin
      r_pc <= w_taken ? w_target : w_fall;
    end else if (stall) begin
      r_pc <= r_pc;
    end else if (w_pred_taken) begin
      r_pc <= w_pred_target;
    end else begin
      r_pc <= r_pc + PC_STEP;
    end
  end

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed bench for branch_pc_unit; predictor steps run when BRANCH_PREDICT_EN is defined.
module tb_branch_pc_unit;
  import branch_pc_unit_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        stall;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] immediate;
  logic [3:0]  branch_type;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic [31:0] pc;
  logic        pred_taken;
  logic        redirect;
  logic        taken;
  logic        misaligned;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  branch_pc_unit #(
    .XLEN        (32),
    .RESET_PC    (32'h0),
    .BTB_ENTRIES (16)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .stall          (stall),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .rs1_data       (rs1_data),
    .rs2_data       (rs2_data),
    .immediate      (immediate),
    .branch_type    (branch_type),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .pc             (pc),
    .pred_taken     (pred_taken),
    .redirect       (redirect),
    .taken          (taken),
    .misaligned     (misaligned)
  );

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ex(input logic [3:0] t, input logic [31:0] epc, input logic [31:0] r1,
                    input logic [31:0] r2, input logic [31:0] imm, input logic pt,
                    input logic [31:0] ptg);
    ex_valid       = 1'b1;
    branch_type    = t;
    ex_pc          = epc;
    rs1_data       = r1;
    rs2_data       = r2;
    immediate      = imm;
    ex_pred_taken  = pt;
    ex_pred_target = ptg;
    #1;
  endtask

  task automatic idle();
    ex_valid       = 1'b0;
    branch_type    = BRANCH_NONE;
    ex_pred_taken  = 1'b0;
    ex_pred_target = 32'h0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    stall   = 1'b0;
    idle();
    // Reset held with a taken branch presented: status outputs stay low
    ex(BRANCH_EQ, 32'h40, 32'd5, 32'd5, 32'hFFFF_FFF0, 1'b0, 32'h0);
    chk1("rst_redirect", redirect, 1'b0);
    chk1("rst_taken", taken, 1'b0);
    tick();
    chk32("rst_pc", pc, 32'h0);
    idle();
    chk1("rst_pred", pred_taken, 1'b0);
    chk1("rst_mis", misaligned, 1'b0);
    reset_n = 1'b1;
    tick(); chk32("seq_pc4", pc, 32'h4);  chk1("seq_redir4", redirect, 1'b0);
    tick(); chk32("seq_pc8", pc, 32'h8);  chk1("seq_redir8", redirect, 1'b0);
    tick(); chk32("seq_pc12", pc, 32'hC); chk1("seq_redir12", redirect, 1'b0);

    // BEQ taken backwards, predicted not-taken
    ex(BRANCH_EQ, 32'h40, 32'd5, 32'd5, 32'hFFFF_FFF0, 1'b0, 32'h0);
    chk1("beq_taken", taken, 1'b1);
    chk1("beq_redirect", redirect, 1'b1);
    chk1("beq_mis", misaligned, 1'b0);
    tick(); chk32("beq_pc", pc, 32'h30);

    // JALR clears bit 0 but leaves bit 1: misaligned yet still redirected
    ex(BRANCH_JALR, 32'h34, 32'h1001, 32'h0, 32'h2, 1'b0, 32'h0);
    chk1("jalr_redirect", redirect, 1'b1);
    chk1("jalr_mis", misaligned, 1'b1);
    tick(); chk32("jalr_pc", pc, 32'h1002);

    stall = 1'b1;
    ex(BRANCH_NE, 32'h100, 32'd7, 32'd7, 32'h40, 1'b0, 32'h0);
    chk1("bne_taken", taken, 1'b0);
    chk1("bne_redirect", redirect, 1'b0);
    tick(); chk32("bne_stall_pc", pc, 32'h1002);

    // Redirect overrides stall; signed vs unsigned compare of 1 and -1
    ex(BRANCH_LTU, 32'h200, 32'h1, 32'hFFFF_FFFF, 32'h20, 1'b0, 32'h0);
    chk1("bltu_taken", taken, 1'b1);
    chk1("bltu_redirect", redirect, 1'b1);
    tick(); chk32("bltu_pc", pc, 32'h220);
    ex(BRANCH_LT, 32'h200, 32'h1, 32'hFFFF_FFFF, 32'h20, 1'b0, 32'h0);
    chk1("blt_taken", taken, 1'b0);
    chk1("blt_redirect", redirect, 1'b0);
    tick(); chk32("blt_pc_hold", pc, 32'h220);
    ex(BRANCH_GE, 32'h200, 32'h1, 32'hFFFF_FFFF, 32'h40, 1'b0, 32'h0);
    chk1("bge_taken", taken, 1'b1);
    tick(); chk32("bge_pc", pc, 32'h240);
    ex(BRANCH_GEU, 32'h200, 32'h1, 32'hFFFF_FFFF, 32'h40, 1'b0, 32'h0);
    chk1("bgeu_taken", taken, 1'b0);
    tick(); chk32("bgeu_pc_hold", pc, 32'h240);

    // NONE predicted taken falls through
    ex(BRANCH_NONE, 32'h500, 32'h0, 32'h0, 32'h0, 1'b1, 32'h700);
    chk1("none_taken", taken, 1'b0);
    chk1("none_redirect", redirect, 1'b1);
    tick(); chk32("none_pc", pc, 32'h504);

    // Target wraps modulo 2^32
    ex(BRANCH_JAL, 32'hFFFF_FFF0, 32'h0, 32'h0, 32'h20, 1'b0, 32'h0);
    chk1("wrap_taken", taken, 1'b1);
    chk1("wrap_mis", misaligned, 1'b0);
    tick(); chk32("wrap_pc", pc, 32'h10);

    stall = 1'b0;
    ex(BRANCH_JAL, 32'h300, 32'h0, 32'h0, 32'h100, 1'b1, 32'h400);
    chk1("jal_okpred_redirect", redirect, 1'b0);
    chk1("jal_okpred_taken", taken, 1'b1);
    tick(); chk32("jal_okpred_pc", pc, 32'h14);
    ex(BRANCH_JAL, 32'h300, 32'h0, 32'h0, 32'h100, 1'b1, 32'h404);
    chk1("jal_badtgt_redirect", redirect, 1'b1);
    tick(); chk32("jal_badtgt_pc", pc, 32'h400);

    // Reset while a redirect is pending
    ex(BRANCH_EQ, 32'h40, 32'd5, 32'd5, 32'hFFFF_FFF0, 1'b0, 32'h0);
    chk1("pend_redirect", redirect, 1'b1);
    reset_n = 1'b0;
    #1;
    chk1("pend_rst_redirect", redirect, 1'b0);
    chk1("pend_rst_taken", taken, 1'b0);
    tick(); chk32("pend_rst_pc", pc, 32'h0);
    reset_n = 1'b1;
    idle();
    chk1("pend_rst_pred", pred_taken, 1'b0);
    tick(); chk32("post_rst_pc", pc, 32'h4);

`ifdef BRANCH_PREDICT_EN
    stall = 1'b1;
    ex(BRANCH_EQ, 32'h80, 32'd3, 32'd3, 32'hFFFF_FFF0, 1'b0, 32'h0);
    chk1("loop1_redirect", redirect, 1'b1);
    tick(); chk32("loop1_pc", pc, 32'h70);
    ex(BRANCH_EQ, 32'h80, 32'd3, 32'd3, 32'hFFFF_FFF0, 1'b1, 32'h70);
    chk1("loop2_redirect", redirect, 1'b0);
    tick(); chk32("loop2_pc", pc, 32'h70);
    ex(BRANCH_JAL, 32'h7C, 32'h0, 32'h0, 32'h4, 1'b0, 32'h0);
    tick(); chk32("to80_pc", pc, 32'h80);
    idle();
    chk1("pred_at80", pred_taken, 1'b1);
    ex(BRANCH_EQ, 32'h80, 32'd3, 32'd4, 32'hFFFF_FFF0, 1'b1, 32'h70);
    chk1("exit_taken", taken, 1'b0);
    chk1("exit_redirect", redirect, 1'b1);
    tick(); chk32("exit_pc", pc, 32'h84);
    idle();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
